// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: shared types and constants for the bit-serial magnitude comparator.
//   state_e      : FSM states (IDLE, SHIFT, DONE)
//   GT / EQ / LT : one-hot result codes, ordered {a_greater, a_equal, a_lesser}
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

endpackage

// File: rtl/serial_cmp_cell.sv
// serial_cmp_cell: one step of an MSB-first serial compare.
// Ports:
//   a_bit_i, b_bit_i : current operand bits
//   dec_i, gt_i      : sticky decision so far (decided, A-greater)
//   dec_o, gt_o      : decision after this bit
module serial_cmp_cell (
    input  logic a_bit_i,
    input  logic b_bit_i,
    input  logic dec_i,
    input  logic gt_i,
    output logic dec_o,
    output logic gt_o
);

    // Once decided, later (less significant) bits cannot change the outcome.
    assign dec_o = dec_i | (a_bit_i ^ b_bit_i);
    assign gt_o  = dec_i ? gt_i : (a_bit_i & ~b_bit_i);

endmodule

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator: bit-serial unsigned magnitude comparator, MSB first,
// with valid/ready handshakes on both sides. One bit is scanned per cycle.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish as soon as the first differing
// bit is seen; without it every compare takes exactly N cycles (constant time).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake (ready only in IDLE, out of reset)
//   a, b                  : unsigned N-bit operands
//   out_valid/out_ready   : result handshake
//   a_greater/a_equal/a_lesser : registered one-hot result, held until next result
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         a_greater,
    output logic         a_equal,
    output logic         a_lesser
);

    localparam int IW = $clog2(N);

    state_e        state_q, state_d;
    logic [N-1:0]  sa_q, sa_d;
    logic [N-1:0]  sb_q, sb_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          dec_q, dec_d;
    logic          gt_q, gt_d;
    logic [2:0]    flags_q, flags_d;

    logic          dec_n, gt_n;
    logic          last_bit, finish;

    serial_cmp_cell u_cell (
        .a_bit_i (sa_q[N-1]),
        .b_bit_i (sb_q[N-1]),
        .dec_i   (dec_q),
        .gt_i    (gt_q),
        .dec_o   (dec_n),
        .gt_o    (gt_n)
    );

    assign last_bit = (idx_q == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    // dec_q is always clear while still in SHIFT here, so dec_n marks the first difference.
    assign finish = last_bit | dec_n;
`else
    assign finish = last_bit;
`endif

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign {a_greater, a_equal, a_lesser} = flags_q;

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        idx_d   = idx_q;
        dec_d   = dec_q;
        gt_d    = gt_q;
        flags_d = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sa_d    = a;
                    sb_d    = b;
                    idx_d   = IW'(N - 1);
                    dec_d   = 1'b0;
                    gt_d    = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sa_d  = sa_q << 1;
                sb_d  = sb_q << 1;
                idx_d = idx_q - IW'(1);
                dec_d = dec_n;
                gt_d  = gt_n;
                if (finish) begin
                    state_d = DONE;
                    flags_d = dec_n ? (gt_n ? GT : LT) : EQ;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            gt_q    <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            idx_q   <= idx_d;
            dec_q   <= dec_d;
            gt_q    <= gt_d;
            flags_q <= flags_d;
        end
    end

endmodule
